// File: rtl/ensemble_vote_collector.sv
// ensemble_vote_collector: aligns three classifier result streams per sample and emits a majority-voted result.
// Ports: clk, rst (sync, active-high); s_axis_*_0/1/2 classifier result streams (tkeep ignored);
// m_axis_* voted result stream {agree, label}; err_tlast_mismatch, err_timeout sticky error flags;
// sample_count voted samples emitted. Optional macro VOTE_STATS_EN adds stats_clr and
// cnt_unanimous/cnt_majority/cnt_tiebreak saturating agreement counters.
module ensemble_vote_collector #(
    parameter int DATA_WIDTH     = 32,
    parameter int KEEP_WIDTH     = 4,
    parameter int CLASS_W        = 8,
    parameter int TIE_IDX        = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_0,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_0,
    input  logic                  s_axis_tvalid_0,
    output logic                  s_axis_tready_0,
    input  logic                  s_axis_tlast_0,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
    input  logic                  s_axis_tvalid_1,
    output logic                  s_axis_tready_1,
    input  logic                  s_axis_tlast_1,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
    input  logic                  s_axis_tvalid_2,
    output logic                  s_axis_tready_2,
    input  logic                  s_axis_tlast_2,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  err_tlast_mismatch,
    output logic                  err_timeout,
`ifdef VOTE_STATS_EN
    input  logic                  stats_clr,
    output logic [15:0]           cnt_unanimous,
    output logic [15:0]           cnt_majority,
    output logic [15:0]           cnt_tiebreak,
`endif
    output logic [15:0]           sample_count
);
    typedef enum logic [1:0] {COLLECT, VOTE, EMIT} state_t;
    state_t state_q, state_d;
    logic [CLASS_W-1:0] lbl_q [3];
    logic [CLASS_W-1:0] in_lbl [3];
    logic [2:0] last_q, h_q, h_d, acc, in_last, rdy;
    logic [31:0] tcnt_q, tcnt_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic mlast_q, etl_q, eto_q, partial, tmo, m_hs, e01, e02, e12;
    logic [15:0] cnt_q;
    logic [CLASS_W-1:0] win;
    logic [1:0] agree;
    logic unused_ok;

    assign unused_ok = ^{s_axis_tkeep_0, s_axis_tkeep_1, s_axis_tkeep_2,
                         s_axis_tdata_0, s_axis_tdata_1, s_axis_tdata_2};
    assign in_lbl[0] = s_axis_tdata_0[CLASS_W-1:0];
    assign in_lbl[1] = s_axis_tdata_1[CLASS_W-1:0];
    assign in_lbl[2] = s_axis_tdata_2[CLASS_W-1:0];
    assign in_last = {s_axis_tlast_2, s_axis_tlast_1, s_axis_tlast_0};
    assign rdy = {3{state_q == COLLECT}} & ~h_q;
    assign {s_axis_tready_2, s_axis_tready_1, s_axis_tready_0} = rdy;
    assign acc = rdy & {s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};
    assign m_axis_tvalid = state_q == EMIT;
    assign m_axis_tdata = data_q;
    assign m_axis_tlast = mlast_q;
    assign m_axis_tkeep = '1;
    assign err_tlast_mismatch = etl_q;
    assign err_timeout = eto_q;
    assign sample_count = cnt_q;
    assign m_hs = m_axis_tvalid & m_axis_tready;
    // A sample is partial while some but not all inputs are held.
    assign partial = (h_q != 3'b000) && (h_q != 3'b111);
    // Timeout wins over a completing beat on the same cycle: that beat is dropped too.
    assign tmo = (TIMEOUT_CYCLES > 0) && (state_q == COLLECT) && partial &&
                 (tcnt_q == 32'(TIMEOUT_CYCLES - 1));
    assign e01 = lbl_q[0] == lbl_q[1];
    assign e02 = lbl_q[0] == lbl_q[2];
    assign e12 = lbl_q[1] == lbl_q[2];
    assign win = (e01 | e02) ? lbl_q[0] : e12 ? lbl_q[1] : lbl_q[TIE_IDX[1:0]];
    assign agree = (e01 & e12) ? 2'd3 : (e01 | e02 | e12) ? 2'd2 : 2'd1;

    always_comb begin
        state_d = state_q;
        h_d = h_q;
        tcnt_d = '0;
        if (state_q == COLLECT) begin
            h_d = tmo ? 3'b000 : (h_q | acc);
            state_d = (!tmo && (h_q | acc) == 3'b111) ? VOTE : COLLECT;
            tcnt_d = (partial && !tmo) ? tcnt_q + 32'd1 : '0;
        end else if (state_q == VOTE) begin
            state_d = EMIT;
        end else if (m_hs) begin
            h_d = 3'b000;
            state_d = COLLECT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            h_q <= '0;
            last_q <= '0;
            tcnt_q <= '0;
            data_q <= '0;
            mlast_q <= 1'b0;
            etl_q <= 1'b0;
            eto_q <= 1'b0;
            cnt_q <= '0;
            for (int k = 0; k < 3; k++) lbl_q[k] <= '0;
        end else begin
            state_q <= state_d;
            h_q <= h_d;
            tcnt_q <= tcnt_d;
            for (int k = 0; k < 3; k++) begin
                if (acc[k]) begin
                    lbl_q[k] <= in_lbl[k];
                    last_q[k] <= in_last[k];
                end
            end
            if (state_q == VOTE) begin
                data_q <= DATA_WIDTH'({agree, win});
                mlast_q <= &last_q;
                etl_q <= etl_q | ((|last_q) & ~(&last_q));
            end
            if (tmo) eto_q <= 1'b1;
            if (m_hs) cnt_q <= cnt_q + 16'd1;
        end
    end

`ifdef VOTE_STATS_EN
    logic [15:0] cu_q, cm_q, ct_q;
    logic [1:0] ag;
    assign ag = data_q[CLASS_W+1:CLASS_W];
    assign cnt_unanimous = cu_q;
    assign cnt_majority = cm_q;
    assign cnt_tiebreak = ct_q;

    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            cu_q <= '0;
            cm_q <= '0;
            ct_q <= '0;
        end else begin
            cu_q <= cu_q + 16'(m_hs && ag == 2'd3 && cu_q != 16'hFFFF);
            cm_q <= cm_q + 16'(m_hs && ag == 2'd2 && cm_q != 16'hFFFF);
            ct_q <= ct_q + 16'(m_hs && ag == 2'd1 && ct_q != 16'hFFFF);
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif
endmodule

// File: tb/tb_ensemble_vote_collector.sv
// tb_ensemble_vote_collector: scoreboard bench for the voted result stream.
module tb_ensemble_vote_collector;
    localparam int TIE = 2;
    localparam int TMO = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] td [3];
    logic tv [3];
    logic tl [3];
    logic tr [3];
    logic [31:0] mdata;
    logic [3:0] mkeep;
    logic mvalid, mready, mlast, etl, eto;
    logic [15:0] scnt;
    int ntot = 0;
    int npass = 0;
    int nexp = 0;
    bit exp_etl = 1'b0;
    bit rnd_done = 1'b0;
    bit mon_stall = 1'b0;
    logic [32:0] mon_prev, mon_e;
    logic [32:0] expq [$];
    int nagree [4] = '{0, 0, 0, 0};
`ifdef VOTE_STATS_EN
    logic sclr = 1'b0;
    logic [15:0] cu, cm, ct;
`endif

    always #5 clk = ~clk;

    ensemble_vote_collector #(.TIE_IDX(TIE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata_0(td[0]), .s_axis_tkeep_0(4'hF), .s_axis_tvalid_0(tv[0]), .s_axis_tready_0(tr[0]), .s_axis_tlast_0(tl[0]),
        .s_axis_tdata_1(td[1]), .s_axis_tkeep_1(4'hF), .s_axis_tvalid_1(tv[1]), .s_axis_tready_1(tr[1]), .s_axis_tlast_1(tl[1]),
        .s_axis_tdata_2(td[2]), .s_axis_tkeep_2(4'hF), .s_axis_tvalid_2(tv[2]), .s_axis_tready_2(tr[2]), .s_axis_tlast_2(tl[2]),
        .m_axis_tdata(mdata), .m_axis_tkeep(mkeep), .m_axis_tvalid(mvalid), .m_axis_tready(mready), .m_axis_tlast(mlast),
        .err_tlast_mismatch(etl), .err_timeout(eto),
`ifdef VOTE_STATS_EN
        .stats_clr(sclr), .cnt_unanimous(cu), .cnt_majority(cm), .cnt_tiebreak(ct),
`endif
        .sample_count(scnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference vote: count occurrences of each label; the most frequent wins, singletons defer to TIE.
    function automatic logic [31:0] model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [7:0] l [3];
        logic [7:0] w;
        int best, n;
        l = '{a, b, c};
        best = 0;
        w = l[TIE];
        for (int i = 0; i < 3; i++) begin
            n = 0;
            for (int j = 0; j < 3; j++) n += (l[j] == l[i]) ? 1 : 0;
            if (n > best) begin
                best = n;
                w = l[i];
            end
        end
        if (best == 1) w = l[TIE];
        return (32'(best) << 8) | 32'(w);
    endfunction

    task automatic drive(input int k, input logic [7:0] lbl, input bit last, input int dly);
        bit done = 1'b0;
        repeat (dly) @(posedge clk);
        #1;
        td[k] = $urandom();
        td[k][7:0] = lbl;
        tl[k] = last;
        tv[k] = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = tr[k];
            @(posedge clk);
        end
        #1 tv[k] = 1'b0;
        if (!done) begin
            ntot++;
            $display("FAIL drive_timeout: input %0d got no handshake, required one", k);
        end
    endtask

    task automatic sample(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input bit la, input bit lb, input bit lc,
                          input int da, input int db, input int dc, input bit expect_out);
        logic [31:0] m;
        if (expect_out) begin
            m = model(a, b, c);
            expq.push_back({la & lb & lc, m});
            nexp++;
            nagree[m[9:8]]++;
            if (!(la == lb && lb == lc)) exp_etl = 1'b1;
        end
        fork
            drive(0, a, la, da);
            drive(1, b, lb, db);
            drive(2, c, lc, dc);
        join
    endtask

    task automatic drain();
        for (int i = 0; i < 1000 && expq.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        if (expq.size() != 0) begin
            ntot++;
            $display("FAIL drain: %0d outputs outstanding, required 0", expq.size());
        end
    endtask

    always @(negedge clk) begin
        if (rst) mon_stall = 1'b0;
        else begin
            if (mon_stall) begin
                chk("hold_valid", 32'(mvalid), 1);
                chk("hold_data", mdata, mon_prev[31:0]);
                chk("hold_last", 32'(mlast), 32'(mon_prev[32]));
                chk("hold_treadys", {29'd0, tr[0], tr[1], tr[2]}, 0);
            end
            if (mvalid && mready) begin
                if (expq.size() == 0) begin
                    ntot++;
                    $display("FAIL spurious_out: got 0x%0h, required no output", mdata);
                end else begin
                    mon_e = expq.pop_front();
                    chk("out_data", mdata, mon_e[31:0]);
                    chk("out_last", 32'(mlast), 32'(mon_e[32]));
                    chk("out_keep", 32'(mkeep), 32'hF);
                end
            end
            mon_stall = mvalid && !mready;
            mon_prev = {mlast, mdata};
        end
    end

    initial begin
        logic [7:0] a, b, c;
        bit la, lb, lc;
        mready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            td[k] = '0;
            tv[k] = 1'b0;
            tl[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_tvalid", 32'(mvalid), 0);
        chk("rst_tdata", mdata, 0);
        chk("rst_tlast", 32'(mlast), 0);
        chk("rst_count", 32'(scnt), 0);
        chk("rst_errs", {30'd0, etl, eto}, 0);
        chk("rst_treadys", {29'd0, tr[0], tr[1], tr[2]}, 7);

        sample(5, 5, 5, 0, 0, 0, 0, 0, 0, 1);
        drain();
        chk("count_first", 32'(scnt), 1);

        fork
            sample(3, 7, 3, 0, 0, 0, 0, 4, 9, 1);
            begin
                repeat (6) @(posedge clk);
                #1 chk("held_treadys", {29'd0, tr[0], tr[1], tr[2]}, 1);
            end
        join
        sample(1, 2, 4, 0, 0, 0, 1, 0, 2, 1);
        drain();

        mready = 1'b0;
        sample(4, 4, 1, 0, 0, 0, 0, 1, 0, 1);
        fork
            sample(9, 0, 9, 0, 0, 0, 0, 0, 0, 1);
            begin
                repeat (12) @(posedge clk);
                #1 mready = 1'b1;
            end
        join
        drain();

        sample(8, 3, 8, 1, 1, 0, 0, 0, 0, 1);
        drain();
        chk("tlast_err", 32'(etl), 1);

        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    a = 8'($urandom_range(0, 3));
                    b = 8'($urandom_range(0, 3));
                    c = 8'($urandom_range(0, 3));
                    la = 1'($urandom_range(0, 1));
                    lb = la;
                    lc = la;
                    if ($urandom_range(0, 7) == 0) begin
                        lb = 1'($urandom_range(0, 1));
                        lc = 1'($urandom_range(0, 1));
                    end
                    sample(a, b, c, la, lb, lc, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), 1);
                end
                rnd_done = 1'b1;
            end
            while (!rnd_done) begin
                @(posedge clk);
                #1 mready = ($urandom_range(0, 3) != 0);
            end
        join
        mready = 1'b1;
        drain();
        chk("count_random", 32'(scnt), 32'(16'(nexp)));
        chk("tlast_err_random", 32'(etl), 32'(exp_etl));
`ifdef VOTE_STATS_EN
        chk("stat_unanimous", 32'(cu), nagree[3]);
        chk("stat_majority", 32'(cm), nagree[2]);
        chk("stat_tiebreak", 32'(ct), nagree[1]);
`endif

        chk("timeout_pre", 32'(eto), 0);
        fork
            drive(0, 2, 0, 0);
            drive(1, 2, 0, 2);
        join
        repeat (8) @(posedge clk);
        #1 chk("timeout_early", 32'(eto), 0);
        repeat (20) @(posedge clk);
        #1 chk("timeout_set", 32'(eto), 1);
        chk("timeout_flush", {29'd0, tr[0], tr[1], tr[2]}, 7);
        sample(2, 2, 9, 0, 0, 0, 0, 0, 0, 1);
        drain();
        chk("count_timeout", 32'(scnt), 32'(16'(nexp)));

        mready = 1'b0;
        sample(6, 6, 6, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 50 && !mvalid; i++) @(negedge clk);
        chk("emit_before_rst", 32'(mvalid), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_emit_tvalid", 32'(mvalid), 0);
        chk("rst_emit_tdata", mdata, 0);
        chk("rst_emit_count", 32'(scnt), 0);
        chk("rst_emit_errs", {30'd0, etl, eto}, 0);
`ifdef VOTE_STATS_EN
        chk("rst_emit_stats", {cu, cm | ct}, 0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        mready = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("post_rst_idle", 32'(mvalid), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
